// File: rtl/error_stats_collector.sv
// Error statistics for one regression pass: sum of |err|, max |err| and its index.
// Results are held after the done pulse until the next start or reset.
module error_stats_collector #(
  parameter int N_SAMPLES = 150,
  parameter int ERR_W     = 20,
  parameter int IDX_W     = 8,
  parameter int SUM_W     = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             err_valid,
  input  logic [ERR_W-1:0] err_in,
  output logic             err_ready,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] sum_abs,
  output logic [ERR_W-1:0] max_abs,
  output logic [IDX_W-1:0] max_idx,
  output logic [IDX_W-1:0] count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_SAMPLES - 1);

  logic [1:0]       state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [ERR_W-1:0] max_q, max_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic [ERR_W-1:0] abs_v;
  logic             xfer;

  // Most negative input wraps to 2**(ERR_W-1), exact as unsigned.
  assign abs_v = err_in[ERR_W-1] ? (~err_in + ERR_W'(1)) : err_in;
  assign xfer  = err_valid & (state_q == S_ACC);

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    max_d   = max_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACC;
          sum_d   = '0;
          max_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      S_ACC: begin
        if (xfer) begin
          sum_d = sum_q + SUM_W'(abs_v);
          if (abs_v > max_q) begin
            max_d = abs_v;
            idx_d = cnt_q;
          end
          cnt_d = cnt_q + IDX_W'(1);
          if (cnt_q == LAST) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sum_q   <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign err_ready = (state_q == S_ACC);
  assign busy      = (state_q == S_ACC);
  assign done      = (state_q == S_DONE);
  assign sum_abs   = sum_q;
  assign max_abs   = max_q;
  assign max_idx   = idx_q;
  assign count     = cnt_q;

endmodule
